// File: rtl/fir_axi_regbank_if.sv
// AXI4-Lite bus bundle for the FIR register bank: write, response and read channels.
// The slave modport is the register bank's view; the master modport is the interconnect's.
interface fir_axi_regbank_if #(
  parameter int DW = 32,
  parameter int AW = 6
) ();
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/fir_axi_regbank.sv
// AXI4-Lite register bank for the FIR core: RW/RO registers with per-register push/pop strobes.
// AW and W are held independently and committed together; reads return in the handshake cycle.
module fir_axi_regbank #(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = 8'b0010_0010,
  parameter logic [NUM_REGS-1:0] PULSE_MASK         = 8'b0001_0000
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  fir_axi_regbank_if.slave                       s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  output logic [NUM_REGS-1:0]                    rd_pulse
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
  localparam int IDX_W    = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [DW-1:0]    word_t;
  typedef logic [AW-1:0]    addr_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t addr_idx(input addr_t a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  // Any set bit above the index field aliases outside the bank and must not decode.
  function automatic logic addr_mapped(input addr_t a);
    return (int'(addr_idx(a)) < NUM_REGS) && ((a >> (ADDR_LSB + IDX_W)) == '0);
  endfunction

  logic          aw_full_q, aw_full_d;
  addr_t         aw_addr_q, aw_addr_d;
  logic          w_full_q,  w_full_d;
  word_t         w_data_q,  w_data_d;
  logic [SW-1:0] w_strb_q,  w_strb_d;
  logic          bvalid_q,  bvalid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic          rvalid_q,  rvalid_d;
  word_t         rdata_q,   rdata_d;
  logic [1:0]    rresp_q,   rresp_d;
  word_t         regs_q [NUM_REGS];
  word_t         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;

  logic awready, wready, arready;
  idx_t aw_idx, ar_idx;

  assign awready = !aw_full_q && !bvalid_q;
  assign wready  = !w_full_q  && !bvalid_q;
  assign arready = !rvalid_q;
  assign aw_idx  = addr_idx(aw_addr_q);
  assign ar_idx  = addr_idx(s_axi.S_AXI_ARADDR);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;

    if (s_axi.S_AXI_AWVALID && awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi.S_AXI_AWADDR;
    end
    if (s_axi.S_AXI_WVALID && wready) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.S_AXI_WDATA;
      w_strb_d = s_axi.S_AXI_WSTRB;
    end

    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    // Both holding stages are only ever full together while BVALID is low.
    if (aw_full_q && w_full_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (addr_mapped(aw_addr_q) && !RO_MASK[aw_idx]) begin
        bresp_d = RESP_OKAY;
        for (int b = 0; b < SW; b++) begin
          if (w_strb_q[b]) regs_d[aw_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
        end
        wr_pulse_d[aw_idx] = PULSE_MASK[aw_idx];
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;

    if (s_axi.S_AXI_ARVALID && arready) begin
      rvalid_d = 1'b1;
      if (!addr_mapped(s_axi.S_AXI_ARADDR)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (RO_MASK[ar_idx]) begin
        rdata_d = reg_in[int'(ar_idx)*DW +: DW];
        rresp_d = RESP_OKAY;
        rd_pulse_d[ar_idx] = 1'b1;
      end else begin
        rdata_d = regs_q[ar_idx];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      // NOTE: the register array is software-visible state, so it is reset like any other flop.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DW +: DW] = regs_q[i];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign wr_pulse            = wr_pulse_q;
  assign rd_pulse            = rd_pulse_q;

  logic unused_prot;
  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
endmodule

// File: tb/tb_fir_axi_regbank.sv
// Directed bench for fir_axi_regbank: a vector table of single transactions plus
// hand-timed sequences for split AW/W, B backpressure, write/read collisions and mid-write reset.
module tb_fir_axi_regbank;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_axi_regbank_if #(.DW(DW), .AW(AW)) axi ();
  logic [N*DW-1:0] reg_out;
  logic [N*DW-1:0] reg_in;
  logic [N-1:0]    wr_pulse;
  logic [N-1:0]    rd_pulse;

  fir_axi_regbank dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within 64 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready depends only on DUT flops, so a value sampled 1 ns after an edge holds until the next one.
  task automatic aw_send(input logic [AW-1:0] addr);
    bit done = 0;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      done = axi.S_AXI_AWREADY;
      tick();
    end
    axi.S_AXI_AWVALID = 1'b0;
    if (!done) timeout("aw_handshake");
  endtask

  task automatic w_send(input logic [DW-1:0] data, input logic [3:0] strb);
    bit done = 0;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = strb;
    axi.S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      done = axi.S_AXI_WREADY;
      tick();
    end
    axi.S_AXI_WVALID = 1'b0;
    if (!done) timeout("w_handshake");
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [N-1:0] wp0, output logic [N-1:0] wp1);
    bit done = 0;
    resp = 2'bxx;
    wp0  = 'x;
    axi.S_AXI_BREADY = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      if (axi.S_AXI_BVALID) begin
        done = 1;
        resp = axi.S_AXI_BRESP;
        wp0  = wr_pulse;
      end
      tick();
    end
    axi.S_AXI_BREADY = 1'b0;
    wp1 = wr_pulse;
    if (!done) timeout("b_handshake");
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int w_delay, output logic [1:0] resp,
                           output logic [N-1:0] wp0, output logic [N-1:0] wp1);
    fork
      aw_send(addr);
      begin
        repeat (w_delay) tick();
        w_send(data, strb);
      end
    join
    b_recv(resp, wp0, wp1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp,
                          output logic [N-1:0] rp0, output logic [N-1:0] rp1);
    bit done = 0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      done = axi.S_AXI_ARREADY;
      tick();
    end
    axi.S_AXI_ARVALID = 1'b0;
    if (!done) timeout("ar_handshake");
    check("rvalid_after_ar", 32'(axi.S_AXI_RVALID), 1);
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    rp0  = rd_pulse;
    axi.S_AXI_RREADY = 1'b1;
    tick();
    axi.S_AXI_RREADY = 1'b0;
    rp1 = rd_pulse;
    check("rvalid_after_rready", 32'(axi.S_AXI_RVALID), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(axi.S_AXI_AWREADY), 1);
    check({tag, "_wready"},  32'(axi.S_AXI_WREADY), 1);
    check({tag, "_arready"}, 32'(axi.S_AXI_ARREADY), 1);
    check({tag, "_bvalid"},  32'(axi.S_AXI_BVALID), 0);
    check({tag, "_bresp"},   32'(axi.S_AXI_BRESP), 0);
    check({tag, "_rvalid"},  32'(axi.S_AXI_RVALID), 0);
    check({tag, "_rdata"},   axi.S_AXI_RDATA, 0);
    check({tag, "_rresp"},   32'(axi.S_AXI_RRESP), 0);
    check({tag, "_reg_out_zero"}, 32'(reg_out == '0), 1);
    check({tag, "_wr_pulse"}, 32'(wr_pulse), 0);
    check({tag, "_rd_pulse"}, 32'(rd_pulse), 0);
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  pulse;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish before 200 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    resp;
    logic [N-1:0]  p0, p1;
    logic [DW-1:0] rdata;
    logic [N*DW-1:0] snap;

    vecs[0]  = '{1'b1, 6'h00, 32'hDEADBEEF, 4'b0011, 2'b00, 32'h0,        8'h00};
    vecs[1]  = '{1'b0, 6'h00, 32'h0,        4'b0000, 2'b00, 32'h0000BEEF, 8'h00};
    vecs[2]  = '{1'b1, 6'h18, 32'h12345678, 4'b1111, 2'b00, 32'h0,        8'h00};
    vecs[3]  = '{1'b1, 6'h18, 32'hAABBCCDD, 4'b0100, 2'b00, 32'h0,        8'h00};
    vecs[4]  = '{1'b0, 6'h18, 32'h0,        4'b0000, 2'b00, 32'h12BB5678, 8'h00};
    vecs[5]  = '{1'b1, 6'h1C, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'h0,        8'h00};
    vecs[6]  = '{1'b0, 6'h1C, 32'h0,        4'b0000, 2'b00, 32'h00000000, 8'h00};
    vecs[7]  = '{1'b1, 6'h10, 32'h00000777, 4'b0000, 2'b00, 32'h0,        8'h10};
    vecs[8]  = '{1'b0, 6'h10, 32'h0,        4'b0000, 2'b00, 32'h00000000, 8'h00};
    vecs[9]  = '{1'b1, 6'h14, 32'h00000001, 4'b1111, 2'b10, 32'h0,        8'h00};
    vecs[10] = '{1'b0, 6'h24, 32'h0,        4'b0000, 2'b10, 32'h00000000, 8'h00};
    vecs[11] = '{1'b0, 6'h04, 32'h0,        4'b0000, 2'b00, 32'h00000A5A, 8'h02};
    vecs[12] = '{1'b0, 6'h14, 32'h0,        4'b0000, 2'b00, 32'h00005555, 8'h20};
    vecs[13] = '{1'b1, 6'h0C, 32'hCAFEF00D, 4'b1010, 2'b00, 32'h0,        8'h00};
    vecs[14] = '{1'b0, 6'h0C, 32'h0,        4'b0000, 2'b00, 32'hCA00F000, 8'h00};

    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    reg_in = '0;
    reg_in[1*DW +: DW] = 32'h00000A5A;
    reg_in[5*DW +: DW] = 32'h00005555;

    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Same-cycle AW and W: handshake at edge N, BVALID at N+1.
    axi.S_AXI_AWADDR = 6'h00;
    axi.S_AXI_WDATA  = 32'hDEADBEEF;
    axi.S_AXI_WSTRB  = 4'b0011;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("t1_bvalid_at_handshake", 32'(axi.S_AXI_BVALID), 0);
    tick();
    check("t1_bvalid_next_cycle", 32'(axi.S_AXI_BVALID), 1);
    check("t1_bresp", 32'(axi.S_AXI_BRESP), 0);
    check("t1_reg0", reg_out[31:0], 32'h0000BEEF);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    check("t1_bvalid_drop", 32'(axi.S_AXI_BVALID), 0);
    axi_read(6'h00, rdata, resp, p0, p1);
    check("t1_read_data", rdata, 32'h0000BEEF);
    check("t1_read_resp", 32'(resp), 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp, p0, p1);
        check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("vec%0d_wr_pulse", i), 32'(p0), 32'(vecs[i].pulse));
        check($sformatf("vec%0d_wr_pulse_end", i), 32'(p1), 0);
      end else begin
        axi_read(vecs[i].addr, rdata, resp, p0, p1);
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
        check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("vec%0d_rd_pulse", i), 32'(p0), 32'(vecs[i].pulse));
        check($sformatf("vec%0d_rd_pulse_end", i), 32'(p1), 0);
      end
    end

    // Split AW/W with B backpressure: a second AW must wait out BVALID.
    axi.S_AXI_AWADDR  = 6'h10;
    axi.S_AXI_AWVALID = 1'b1;
    check("t2_awready", 32'(axi.S_AXI_AWREADY), 1);
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    tick();
    tick();
    axi.S_AXI_WDATA  = 32'h00000123;
    axi.S_AXI_WSTRB  = 4'b1111;
    axi.S_AXI_WVALID = 1'b1;
    check("t2_wready", 32'(axi.S_AXI_WREADY), 1);
    tick();
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_AWADDR  = 6'h00;
    axi.S_AXI_AWVALID = 1'b1;
    check("t2_bvalid_before_commit", 32'(axi.S_AXI_BVALID), 0);
    check("t2_awready_aw_held", 32'(axi.S_AXI_AWREADY), 0);
    tick();
    check("t2_bvalid_commit", 32'(axi.S_AXI_BVALID), 1);
    check("t2_bresp", 32'(axi.S_AXI_BRESP), 0);
    check("t2_wr_pulse", 32'(wr_pulse), 32'h10);
    check("t2_reg4", reg_out[4*DW +: DW], 32'h00000123);
    check("t2_awready_bvalid0", 32'(axi.S_AXI_AWREADY), 0);
    tick();
    check("t2_bvalid_held", 32'(axi.S_AXI_BVALID), 1);
    check("t2_wr_pulse_end", 32'(wr_pulse), 0);
    check("t2_awready_bvalid1", 32'(axi.S_AXI_AWREADY), 0);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    check("t2_bvalid_drop", 32'(axi.S_AXI_BVALID), 0);
    check("t2_reg0_untouched", reg_out[31:0], 32'h0000BEEF);

    // RO write is refused; RO read samples reg_in and pops.
    snap = reg_out;
    axi_write(6'h04, 32'h00000005, 4'b1111, 0, resp, p0, p1);
    check("t3_ro_bresp", 32'(resp), 32'h2);
    check("t3_ro_no_pulse", 32'(p0), 0);
    check("t3_ro_reg_out_same", 32'(reg_out == snap), 1);
    reg_in[5*DW +: DW] = 32'h0000CAFE;
    tick();
    axi_read(6'h14, rdata, resp, p0, p1);
    check("t3_ro_rdata", rdata, 32'h0000CAFE);
    check("t3_ro_rresp", 32'(resp), 0);
    check("t3_rd_pulse", 32'(p0), 32'h20);
    check("t3_rd_pulse_end", 32'(p1), 0);

    // Unmapped accesses.
    snap = reg_out;
    axi_write(6'h20, 32'h0000FFFF, 4'b1111, 1, resp, p0, p1);
    check("t4_unmapped_bresp", 32'(resp), 32'h2);
    check("t4_unmapped_no_wr_pulse", 32'(p0), 0);
    check("t4_unmapped_reg_out_same", 32'(reg_out == snap), 1);
    axi_read(6'h3C, rdata, resp, p0, p1);
    check("t4_unmapped_rdata", rdata, 0);
    check("t4_unmapped_rresp", 32'(resp), 32'h2);
    check("t4_unmapped_no_rd_pulse", 32'(p0), 0);

    // Read colliding with a write commit sees the old value.
    axi_write(6'h08, 32'h00000011, 4'b1111, 0, resp, p0, p1);
    check("t5_prewrite_bresp", 32'(resp), 0);
    fork
      begin
        logic [1:0]   wresp;
        logic [N-1:0] w0, w1;
        axi.S_AXI_AWADDR  = 6'h08;
        axi.S_AXI_WDATA   = 32'h00000022;
        axi.S_AXI_WSTRB   = 4'b1111;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        b_recv(wresp, w0, w1);
        check("t5_collide_bresp", 32'(wresp), 0);
      end
      begin
        tick();
        axi_read(6'h08, rdata, resp, p0, p1);
      end
    join
    check("t5_collide_read_old", rdata, 32'h00000011);
    check("t5_collide_rresp", 32'(resp), 0);
    axi_read(6'h08, rdata, resp, p0, p1);
    check("t5_read_new", rdata, 32'h00000022);

    // Reset with AW held and W outstanding.
    axi.S_AXI_AWADDR  = 6'h0C;
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("t6_aw_held", 32'(axi.S_AXI_AWREADY), 0);
    check("t6_w_pending", 32'(axi.S_AXI_WREADY), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    axi_write(6'h0C, 32'h0000600D, 4'b1111, 1, resp, p0, p1);
    check("t6_after_reset_bresp", 32'(resp), 0);
    check("t6_after_reset_reg3", reg_out[3*DW +: DW], 32'h0000600D);
    check("t6_after_reset_no_pulse", 32'(p0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
